drive_sequencer: RTL
====================

Name: drive_sequencer

Overview:
- Run/stop and protection sequencer for the VFD/gate-driver datapath.
- Takes the frequency setpoint and enable from the parameter RAM scanner and slews the commanded frequency toward the setpoint at a programmable rate (soft start and soft stop).
- Gates the driver enable and latches over-current faults.
- Sits between the p10_serial parameter scan logic and the vfd/driver frequency input.

Parameters:
- FREQ_BITS, 16: width of the setpoint and the commanded frequency.
- STEP_BITS, 8: width of the per-tick slew step.
- TICK_DIV, 100000: clk cycles per slew tick (1 ms at 100 MHz). Must be at least 2.
- OCD_FILT, 4: consecutive cycles with ocd=1 needed to trip. Must be at least 1.
- RETRY_TICKS, 1000: fault hold-off in ticks. Used only with the optional feature.

Ports:
- clk  in  1  system clock (clk_100m domain)
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request, level-sensitive
- target  in  FREQ_BITS  frequency setpoint
- step  in  STEP_BITS  slew per tick; 0 is treated as 1
- ocd  in  1  over-current comparator, already synchronised to clk
- fault_clr  in  1  single-cycle fault acknowledge
- freq_out  out  FREQ_BITS  commanded frequency to the vfd/driver
- drv_en  out  1  driver output enable
- state  out  3  IDLE=0, RAMP=1, RUN=2, STOP=3, FAULT=4
- at_target  out  1  high when in RUN
- fault  out  1  latched fault flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, freq_out=0, drv_en=0, fault=0, at_target=0. Tick, filter and retry counters are cleared. A reset asserted mid-ramp forces these values at the next edge.
- Tick generator: counter runs 0..TICK_DIV-1 and pulses tick when it reaches TICK_DIV-1. It is cleared on the IDLE->RAMP transition, so the first step lands TICK_DIV cycles after entry.
- OCD filter: counts consecutive cycles with ocd=1 and clears on ocd=0. If ocd is high on cycles k..k+OCD_FILT-1, then from edge k+OCD_FILT: fault=1, state=FAULT, drv_en=0, freq_out=0.
  - This applies in any state, IDLE included.
  - Fault has priority over every other transition.
- Slew arithmetic: computed at FREQ_BITS+1 bits. No wrap and no overshoot.
  - Up: if freq_out+step >= goal, freq_out=goal; otherwise freq_out+step.
  - Down: if freq_out-step <= goal, freq_out=goal; otherwise freq_out-step.
  - Updates happen only on tick cycles.
- Effective run request: run = enable AND target!=0.
- IDLE: freq_out=0, drv_en=0. When run=1, next state is RAMP and drv_en=1 from the same edge.
- RAMP: goal=target, re-read every tick so setpoint changes mid-ramp are followed.
  - When freq_out==goal, go to RUN.
  - When run=0, go to STOP.
- RUN: at_target=1, freq_out held.
  - If target!=freq_out, go to RAMP.
  - If run=0, go to STOP.
- STOP: goal=0, drv_en stays 1.
  - When freq_out reaches 0, go to IDLE and set drv_en=0 on that edge.
  - If run returns to 1, go to RAMP and resume from the current freq_out.
- FAULT: freq_out=0, drv_en=0, fault=1.
  - fault_clr with enable=0 goes to IDLE and sets fault=0 at the next edge.
  - fault_clr with enable=1 is ignored (no unexpected restart).
  - A new ocd trip while in FAULT has no further effect.
- Simultaneous events: an ocd trip and fault_clr on the same edge leaves the block in FAULT. A tick and a run change on the same edge resolve as the state transition first; no step is applied on that edge.

Optional Feature:
- Macro: OCD_AUTORETRY_EN.
- Defined:
  - In FAULT, once ocd=0 and RETRY_TICKS ticks have elapsed with enable=1, the block clears fault and enters RAMP from freq_out=0.
  - At most 3 automatic retries are allowed. The 4th trip latches until a manual fault_clr.
  - fault_clr and entry to IDLE reset the retry count.
- Undefined: no retry counter logic; FAULT exits only by manual clear.

Test Plan:
1. TICK_DIV=10, step=5, target=23, enable rises at cycle 0 -> drv_en=1 at cycle 1; freq_out = 5, 10, 15, 20, 23 at ticks 1-5; state=RUN and at_target=1 after tick 5.
2. From RUN at 23, enable=0 -> state=STOP; freq_out = 18, 13, 8, 3, 0 on successive ticks; state=IDLE and drv_en=0 on the edge freq_out hits 0.
3. OCD_FILT=4, in RUN: ocd high for 3 cycles -> no fault. ocd high for 4 cycles -> fault=1, drv_en=0, freq_out=0, state=4 on the following edge.
4. In FAULT: fault_clr with enable=1 -> stays FAULT. Then enable=0 and fault_clr -> IDLE with fault=0 one cycle later.
5. In RUN at 23, target changed to 10, step=5 -> RAMP; freq_out = 18, 13, 10; then RUN. Also: target set to 0 with enable=1 -> STOP down to 0, then IDLE.
6. rst asserted mid-ramp at freq_out=15 -> next edge: freq_out=0, drv_en=0, state=IDLE. With OCD_AUTORETRY_EN defined and RETRY_TICKS=2, a single trip -> RAMP restarts 2 ticks after ocd falls.

Source files
------------

// File: rtl/drive_sequencer.sv
// rtl/drive_sequencer.sv - Run/stop slew sequencer with filtered over-current fault latch
// Optional over-current auto-retry is compiled in when OCD_AUTORETRY_EN is defined.
module drive_sequencer #(
    parameter int FREQ_BITS   = 16,
    parameter int STEP_BITS   = 8,
    parameter int TICK_DIV    = 100000,
    parameter int OCD_FILT    = 4,
    parameter int RETRY_TICKS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [FREQ_BITS-1:0] target,
    input  logic [STEP_BITS-1:0] step,
    input  logic                 ocd,
    input  logic                 fault_clr,
    output logic [FREQ_BITS-1:0] freq_out,
    output logic                 drv_en,
    output logic [2:0]           state,
    output logic                 at_target,
    output logic                 fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int FILT_W = (OCD_FILT > 1) ? $clog2(OCD_FILT) : 1;
    localparam int SW     = FREQ_BITS + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(OCD_FILT - 1);

    if (TICK_DIV < 2 || OCD_FILT < 1 || RETRY_TICKS < 1) begin : g_bad_params
        $error("drive_sequencer: TICK_DIV >= 2, OCD_FILT >= 1 and RETRY_TICKS >= 1 required");
    end

    state_t               state_q;
    state_t               state_nxt;
    logic [TICK_W-1:0]    tick_cnt;
    logic [FILT_W-1:0]    filt_cnt;
    logic                 tick;
    logic                 trip;
    logic                 run;
    logic                 tick_clr;
    logic                 retry_go;
    logic [FREQ_BITS-1:0] freq_nxt;
    logic                 drv_nxt;
    logic                 fault_nxt;

    logic [SW-1:0]        step_ext;
    logic [SW-1:0]        freq_ext;
    logic [SW-1:0]        up_sum;
    logic [SW-1:0]        dn_diff;
    logic [FREQ_BITS-1:0] up_val;
    logic [FREQ_BITS-1:0] dn_tgt_val;
    logic [FREQ_BITS-1:0] dn_zero_val;
    logic [FREQ_BITS-1:0] ramp_val;

    assign tick = (tick_cnt == TICK_LAST);
    assign trip = ocd && (filt_cnt == FILT_LAST);
    assign run  = enable && (target != '0);

    // One extra bit catches carry on the way up and borrow on the way down.
    assign step_ext    = (step == '0) ? SW'(1) : SW'(step);
    assign freq_ext    = {1'b0, freq_out};
    assign up_sum      = freq_ext + step_ext;
    assign dn_diff     = freq_ext - step_ext;
    assign up_val      = (up_sum >= {1'b0, target}) ? target : up_sum[FREQ_BITS-1:0];
    assign dn_tgt_val  = (dn_diff[FREQ_BITS] || (dn_diff <= {1'b0, target})) ?
                         target : dn_diff[FREQ_BITS-1:0];
    assign dn_zero_val = dn_diff[FREQ_BITS] ? '0 : dn_diff[FREQ_BITS-1:0];
    assign ramp_val    = (target > freq_out) ? up_val : dn_tgt_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            freq_out  <= '0;
            drv_en    <= 1'b0;
            fault     <= 1'b0;
            at_target <= 1'b0;
            tick_cnt  <= '0;
            filt_cnt  <= '0;
        end else begin
            state_q   <= state_nxt;
            freq_out  <= freq_nxt;
            drv_en    <= drv_nxt;
            fault     <= fault_nxt;
            at_target <= (state_nxt == ST_RUN);
            if (tick_clr || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if (!ocd) begin
                filt_cnt <= '0;
            end else if (filt_cnt != FILT_LAST) begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    assign state = state_q;

    // A trip overrides everything; otherwise a run change wins over a tick.
    always_comb begin
        state_nxt = state_q;
        freq_nxt  = freq_out;
        drv_nxt   = drv_en;
        fault_nxt = fault;
        tick_clr  = 1'b0;
        if (trip) begin
            state_nxt = ST_FAULT;
            freq_nxt  = '0;
            drv_nxt   = 1'b0;
            fault_nxt = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    freq_nxt  = '0;
                    drv_nxt   = 1'b0;
                    fault_nxt = 1'b0;
                    if (run) begin
                        state_nxt = ST_RAMP;
                        drv_nxt   = 1'b1;
                        tick_clr  = 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (!run) begin
                        state_nxt = ST_STOP;
                    end else if (freq_out == target) begin
                        state_nxt = ST_RUN;
                    end else if (tick) begin
                        freq_nxt = ramp_val;
                        if (ramp_val == target) begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_nxt = ST_STOP;
                    end else if (target != freq_out) begin
                        state_nxt = ST_RAMP;
                    end
                end
                ST_STOP: begin
                    if (run) begin
                        state_nxt = ST_RAMP;
                    end else if (freq_out == '0) begin
                        state_nxt = ST_IDLE;
                        drv_nxt   = 1'b0;
                    end else if (tick) begin
                        freq_nxt = dn_zero_val;
                        if (dn_zero_val == '0) begin
                            state_nxt = ST_IDLE;
                            drv_nxt   = 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    freq_nxt  = '0;
                    drv_nxt   = 1'b0;
                    fault_nxt = 1'b1;
                    if (fault_clr && !enable) begin
                        state_nxt = ST_IDLE;
                        fault_nxt = 1'b0;
                    end else if (retry_go) begin
                        state_nxt = ST_RAMP;
                        fault_nxt = 1'b0;
                        drv_nxt   = 1'b1;
                        tick_clr  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    freq_nxt  = '0;
                    drv_nxt   = 1'b0;
                    fault_nxt = 1'b0;
                end
            endcase
        end
    end

`ifdef OCD_AUTORETRY_EN
    localparam int HOLD_W = $clog2(RETRY_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RETRY_TICKS);

    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        retry_cnt;
    logic [1:0]        retry_nxt;

    // Hold-off only accumulates while the fault is quiet and a restart is wanted.
    assign retry_go = (retry_cnt != 2'd3) && (hold_cnt == HOLD_LAST) && !ocd && enable;

    always_comb begin
        retry_nxt = retry_cnt;
        if (fault_clr || (state_nxt == ST_IDLE)) begin
            retry_nxt = '0;
        end else if ((state_q == ST_FAULT) && (state_nxt == ST_RAMP)) begin
            retry_nxt = retry_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            retry_cnt <= retry_nxt;
            if ((state_q == ST_FAULT) && !ocd && enable) begin
                if (tick && (hold_cnt != HOLD_LAST)) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign retry_go = 1'b0;
`endif

endmodule
